// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state encoding and address-split helpers for the data cache.
// Optional feature macro used by the cache top: DCACHE_STATS_EN (hit/miss counters).
package dcache_pkg;

    // Controller states: serving hits, filling a line, or pushing a store through.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REFILL = 2'd1,
        WRITE  = 2'd2
    } state_t;

    // Every access is a full word, so the low two byte-select bits never take part.
    localparam int BYTE_BITS = 2;

    function automatic int offsetBits(input int lineWords);
        return $clog2(lineWords);
    endfunction

    function automatic int indexBits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tagBits(input int addressWidth, input int sets, input int lineWords);
        return addressWidth - BYTE_BITS - $clog2(sets) - $clog2(lineWords);
    endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag, valid and data storage for the direct-mapped cache.
// One asynchronous read port, one synchronous write port; valid bits clear on reset.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic [indexBits(SETS)-1:0]        i_rIndex,
    input  logic [offsetBits(LINE_WORDS)-1:0] i_rOffset,
    output logic                              o_rValid,
    output logic [TAG_W-1:0]                  o_rTag,
    output logic [DATA_WIDTH-1:0]             o_rWord,
    input  logic                              i_wEn,
    input  logic [indexBits(SETS)-1:0]        i_wIndex,
    input  logic [offsetBits(LINE_WORDS)-1:0] i_wOffset,
    input  logic [DATA_WIDTH-1:0]             i_wData,
    input  logic                              i_wTagEn,
    input  logic [TAG_W-1:0]                  i_wTag,
    input  logic                              i_wValid
);

    logic [DATA_WIDTH-1:0] r_data [SETS][LINE_WORDS];
    logic [TAG_W-1:0]      r_tag  [SETS];
    logic [SETS-1:0]       r_valid;

    // Data words carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge i_clk) begin
        if (i_wEn) begin
            r_data[i_wIndex][i_wOffset] <= i_wData;
        end
    end

    // Tag and valid update together so a line under refill stays invalid until complete.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_wEn && i_wTagEn) begin
            r_valid[i_wIndex] <= i_wValid;
            r_tag[i_wIndex]   <= i_wTag;
        end
    end

    assign o_rValid = r_valid[i_rIndex];
    assign o_rTag   = r_tag[i_rIndex];
    assign o_rWord  = r_data[i_rIndex][i_rOffset];

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-through, no-write-allocate data cache for the M stage.
// Define DCACHE_STATS_EN to add saturating hit_count_o / miss_count_o outputs.
module dcache
    import dcache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int SETS          = 16,
    parameter int LINE_WORDS    = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     re_i,
    input  logic                     we_i,
    input  logic [ADDRESS_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    data_i,
    output logic [DATA_WIDTH-1:0]    data_o,
    output logic                     stall_o,
    output logic                     mem_req_o,
    output logic                     mem_we_o,
    output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]    mem_rdata_i,
    input  logic                     mem_ready_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]              hit_count_o,
    output logic [31:0]              miss_count_o
`endif
);

    localparam int OFFSET_W = offsetBits(LINE_WORDS);
    localparam int INDEX_W  = indexBits(SETS);
    localparam int TAG_W    = tagBits(ADDRESS_WIDTH, SETS, LINE_WORDS);
    localparam int LOW_W    = BYTE_BITS + OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(LINE_WORDS - 1);

    state_t                   r_state;
    logic [OFFSET_W-1:0]      r_beat;
    logic                     r_memReq;
    logic                     r_memWe;
    logic [ADDRESS_WIDTH-1:0] r_memAddr;
    logic [DATA_WIDTH-1:0]    r_memWdata;
    logic [INDEX_W-1:0]       r_lineIndex;
    logic [TAG_W-1:0]         r_lineTag;

    logic [OFFSET_W-1:0]      w_offset;
    logic [INDEX_W-1:0]       w_index;
    logic [TAG_W-1:0]         w_tag;
    logic                     w_rValid;
    logic [TAG_W-1:0]         w_rTag;
    logic [DATA_WIDTH-1:0]    w_rWord;
    logic                     w_hit;
    logic                     w_readHit;
    logic                     w_wEn;
    logic [INDEX_W-1:0]       w_wIndex;
    logic [OFFSET_W-1:0]      w_wOffset;
    logic [DATA_WIDTH-1:0]    w_wData;
    logic                     w_wTagEn;
    logic                     w_wValid;
    logic                     w_unusedByteBits;

    assign w_offset         = addr_i[BYTE_BITS +: OFFSET_W];
    assign w_index          = addr_i[LOW_W +: INDEX_W];
    assign w_tag            = addr_i[ADDRESS_WIDTH-1 -: TAG_W];
    assign w_unusedByteBits = ^addr_i[BYTE_BITS-1:0];

    dcache_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_array (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_rIndex  (w_index),
        .i_rOffset (w_offset),
        .o_rValid  (w_rValid),
        .o_rTag    (w_rTag),
        .o_rWord   (w_rWord),
        .i_wEn     (w_wEn),
        .i_wIndex  (w_wIndex),
        .i_wOffset (w_wOffset),
        .i_wData   (w_wData),
        .i_wTagEn  (w_wTagEn),
        .i_wTag    (r_lineTag),
        .i_wValid  (w_wValid)
    );

    assign w_hit     = w_rValid && (w_rTag == w_tag);
    assign w_readHit = (r_state == IDLE) && re_i && !we_i && w_hit;
    assign data_o    = w_readHit ? w_rWord : '0;

    assign mem_req_o   = r_memReq;
    assign mem_we_o    = r_memWe;
    assign mem_addr_o  = r_memAddr;
    assign mem_wdata_o = r_memWdata;

    // Pipeline freeze: any store or load miss in IDLE, all of a refill, and a store until accepted.
    always_comb begin
        stall_o = 1'b0;
        case (r_state)
            IDLE:    stall_o = we_i || (re_i && !w_hit);
            REFILL:  stall_o = 1'b1;
            WRITE:   stall_o = !mem_ready_i;
            default: stall_o = 1'b0;
        endcase
    end

    // Array write port: refill beats fill the captured line; an accepted store patches a resident word.
    always_comb begin
        w_wEn     = 1'b0;
        w_wIndex  = w_index;
        w_wOffset = w_offset;
        w_wData   = r_memWdata;
        w_wTagEn  = 1'b0;
        w_wValid  = 1'b0;
        if (!rst_i && (r_state == REFILL) && mem_ready_i) begin
            w_wEn     = 1'b1;
            w_wIndex  = r_lineIndex;
            w_wOffset = r_beat;
            w_wData   = mem_rdata_i;
            w_wTagEn  = 1'b1;
            w_wValid  = (r_beat == LAST_BEAT);
        end else if (!rst_i && (r_state == WRITE) && mem_ready_i && w_hit) begin
            w_wEn = 1'b1;
        end
    end

    // Controller: launches refills and store write-throughs and holds the memory request until accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_memReq    <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memWdata  <= '0;
            r_lineIndex <= '0;
            r_lineTag   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (we_i) begin
                        r_state    <= WRITE;
                        r_memReq   <= 1'b1;
                        r_memWe    <= 1'b1;
                        r_memAddr  <= {addr_i[ADDRESS_WIDTH-1:BYTE_BITS], {BYTE_BITS{1'b0}}};
                        r_memWdata <= data_i;
                    end else if (re_i && !w_hit) begin
                        r_state     <= REFILL;
                        r_beat      <= '0;
                        r_memReq    <= 1'b1;
                        r_memWe     <= 1'b0;
                        r_memAddr   <= {addr_i[ADDRESS_WIDTH-1:LOW_W], {LOW_W{1'b0}}};
                        r_lineIndex <= w_index;
                        r_lineTag   <= w_tag;
                    end
                end
                REFILL: begin
                    if (mem_ready_i) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state  <= IDLE;
                            r_beat   <= '0;
                            r_memReq <= 1'b0;
                        end else begin
                            r_beat    <= r_beat + 1'b1;
                            r_memAddr <= r_memAddr + ADDRESS_WIDTH'(4);
                        end
                    end
                end
                WRITE: begin
                    if (mem_ready_i) begin
                        r_state  <= IDLE;
                        r_memReq <= 1'b0;
                        r_memWe  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_memReq <= 1'b0;
                    r_memWe  <= 1'b0;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    state_t      r_prevState;
    logic [31:0] r_hitCount;
    logic [31:0] r_missCount;

    // Saturating counters; the hit that completes a refilled load is not counted as a hit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prevState <= IDLE;
            r_hitCount  <= '0;
            r_missCount <= '0;
        end else begin
            r_prevState <= r_state;
            if (w_readHit && (r_prevState != REFILL) && (r_hitCount != '1)) begin
                r_hitCount <= r_hitCount + 32'd1;
            end
            if ((r_state == IDLE) && !we_i && re_i && !w_hit && (r_missCount != '1)) begin
                r_missCount <= r_missCount + 32'd1;
            end
        end
    end

    assign hit_count_o  = r_hitCount;
    assign miss_count_o = r_missCount;
`endif

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed bench for dcache with a backing-memory responder,
// a reference memory plus residency model, and a per-cycle compare process.
module tb_dcache;

   logic        clk;
   logic        rst_i;
   logic        re_i;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        stall_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;
   logic        mem_ready_i;
`ifdef DCACHE_STATS_EN
   logic [31:0] hitCount;
   logic [31:0] missCount;
`endif

   int checks = 0;
   int errors = 0;

   logic [31:0] bmem   [1024];
   logic [31:0] refMem [1024];
   bit          loadMem;
   int          readyDelay;
   int          waitCnt;

   bit          modelValid [16];
   logic [23:0] modelTag   [16];

   dcache u_dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .re_i        (re_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .data_i      (data_i),
      .data_o      (data_o),
      .stall_o     (stall_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ready_i (mem_ready_i)
`ifdef DCACHE_STATS_EN
      ,
      .hit_count_o  (hitCount),
      .miss_count_o (missCount)
`endif
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Backing memory: combinational read data, writes land when a store request is accepted.
   assign mem_rdata_i = bmem[mem_addr_o[11:2]];
   assign mem_ready_i = (waitCnt >= readyDelay);

   always @(posedge clk) begin
      if (loadMem) begin
         for (int i = 0; i < 1024; i++) bmem[i] <= 32'hA500_0000 + i;
         bmem[64] <= 32'hDEAD_BEEF;
      end else if (mem_req_o && mem_ready_i && mem_we_o) begin
         bmem[mem_addr_o[11:2]] <= mem_wdata_o;
      end
   end

   // Ready latency: count cycles a request has been held since the last acceptance.
   always @(posedge clk) begin
      if (mem_req_o && !mem_ready_i) waitCnt <= waitCnt + 1;
      else                           waitCnt <= 0;
   end

   // Watchdog so a wedged handshake can never hang the run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Every-cycle checks: completed loads match the reference memory, quiet cycles are quiet,
   // and a store on the bus carries the requested word address and data.
   always @(negedge clk) begin
      if (!rst_i && !loadMem) begin
         if (re_i && !we_i && !stall_o) begin
            checkOutput("loadData", data_o, refMem[addr_i[11:2]]);
         end
         if (!re_i && !we_i) begin
            checkOutput("idleStall", {31'd0, stall_o}, 32'd0);
            checkOutput("idleData", data_o, 32'd0);
            checkOutput("idleReq", {31'd0, mem_req_o}, 32'd0);
         end
         if (mem_req_o && mem_we_o) begin
            checkOutput("storeAddr", mem_addr_o, {addr_i[31:2], 2'b00});
            checkOutput("storeWdata", mem_wdata_o, data_i);
         end
      end
   end

   // One load or store held until the pipeline is released; checks stall length and bus traffic
   // against what the residency model says the access must cost.
   task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] wdata,
                                input int delay, output logic [31:0] rdata, output int stalls);
      logic [31:0] reqAddr[$];
      bit          sawWe;
      bit          sawReadReq;
      bit          done;
      bit          expHit;
      int          expStalls;
      logic [3:0]  idx;
      logic [31:0] base;
      idx        = addr[7:4];
      base       = {addr[31:4], 4'h0};
      expHit     = modelValid[idx] && (modelTag[idx] == addr[31:8]);
      readyDelay = delay;
      re_i       = !isWrite;
      we_i       = isWrite;
      addr_i     = addr;
      data_i     = wdata;
      stalls     = 0;
      rdata      = '0;
      done       = 0;
      sawWe      = 0;
      sawReadReq = 0;
      for (int c = 0; c < 64 && !done; c++) begin
         @(negedge clk);
         if (mem_req_o && mem_ready_i) reqAddr.push_back(mem_addr_o);
         if (mem_req_o && mem_we_o) sawWe = 1;
         if (mem_req_o && !mem_we_o) sawReadReq = 1;
         if (stall_o) stalls++;
         else begin
            done  = 1;
            rdata = data_o;
         end
      end
      checkOutput("completes", {31'd0, done}, 32'd1);
      if (isWrite) begin
         expStalls = 1 + delay;
         checkOutput("storeSawWe", {31'd0, sawWe}, 32'd1);
         checkOutput("storeBeats", reqAddr.size(), 32'd1);
         refMem[addr[11:2]] = wdata;
      end else if (expHit) begin
         expStalls = 0;
         checkOutput("hitNoReq", reqAddr.size(), 32'd0);
      end else begin
         expStalls = 1 + 4 * (1 + delay);
         checkOutput("refillBeats", reqAddr.size(), 32'd4);
         checkOutput("refillNoWe", {31'd0, sawWe}, 32'd0);
         for (int k = 0; k < 4 && k < reqAddr.size(); k++) begin
            checkOutput("refillAddr", reqAddr[k], base + 32'(4 * k));
         end
         modelValid[idx] = 1;
         modelTag[idx]   = addr[31:8];
      end
      if (!isWrite && expHit) checkOutput("hitNoReadReq", {31'd0, sawReadReq}, 32'd0);
      checkOutput("stallCycles", stalls, expStalls);
      @(posedge clk);
      #1;
      re_i = 0;
      we_i = 0;
   endtask

   initial begin
      logic [31:0] rd;
      int          st;
      bit          found;
      $display("[TB] tb_dcache start");
      for (int i = 0; i < 1024; i++) refMem[i] = 32'hA500_0000 + i;
      refMem[64] = 32'hDEAD_BEEF;
      for (int i = 0; i < 16; i++) begin
         modelValid[i] = 0;
         modelTag[i]   = '0;
      end
      loadMem    = 1;
      readyDelay = 0;
      rst_i      = 1;
      re_i       = 0;
      we_i       = 0;
      addr_i     = '0;
      data_i     = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("resetStall", {31'd0, stall_o}, 32'd0);
      checkOutput("resetReq", {31'd0, mem_req_o}, 32'd0);
      checkOutput("resetWe", {31'd0, mem_we_o}, 32'd0);
      checkOutput("resetData", data_o, 32'd0);
      @(posedge clk);
      #1;
      rst_i   = 0;
      loadMem = 0;

      // Cold miss, then same-line hit.
      applyStimulus(0, 32'h100, 32'h0, 0, rd, st);
      checkOutput("s1Data", rd, 32'hDEAD_BEEF);
      checkOutput("s1Stall", st, 32'd5);
      applyStimulus(0, 32'h104, 32'h0, 0, rd, st);
      checkOutput("s2Data", rd, 32'hA500_0041);
      checkOutput("s2Stall", st, 32'd0);
`ifdef DCACHE_STATS_EN
      @(negedge clk);
      checkOutput("statHits", hitCount, 32'd1);
      checkOutput("statMisses", missCount, 32'd1);
      @(posedge clk);
      #1;
`endif

      // Store hit with a slow memory, then read it back from the cache.
      applyStimulus(1, 32'h108, 32'h1234_5678, 3, rd, st);
      checkOutput("s3Stall", st, 32'd4);
      applyStimulus(0, 32'h108, 32'h0, 0, rd, st);
      checkOutput("s3Data", rd, 32'h1234_5678);
      checkOutput("s3HitStall", st, 32'd0);

      // Conflict eviction in set 0.
      applyStimulus(0, 32'h200, 32'h0, 0, rd, st);
      checkOutput("s4Evict", rd, 32'hA500_0080);
      applyStimulus(0, 32'h100, 32'h0, 0, rd, st);
      checkOutput("s4Reload", rd, 32'hDEAD_BEEF);
      checkOutput("s4Stall", st, 32'd5);

      // Store miss does not allocate: the following load still refills.
      applyStimulus(1, 32'h404, 32'h0000_0055, 0, rd, st);
      applyStimulus(0, 32'h404, 32'h0, 0, rd, st);
      checkOutput("s5Data", rd, 32'h0000_0055);
      checkOutput("s5Stall", st, 32'd5);

      // Reset during refill beat 2 abandons the request.
      readyDelay = 0;
      re_i       = 1;
      we_i       = 0;
      addr_i     = 32'h180;
      found      = 0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (mem_req_o && mem_addr_o == 32'h188) found = 1;
      end
      checkOutput("s6ReachBeat2", {31'd0, found}, 32'd1);
      rst_i = 1;
      @(posedge clk);
      #1;
      rst_i = 0;
      re_i  = 0;
      for (int i = 0; i < 16; i++) modelValid[i] = 0;
      @(negedge clk);
      checkOutput("s6ReqDropped", {31'd0, mem_req_o}, 32'd0);
      checkOutput("s6NoStall", {31'd0, stall_o}, 32'd0);
      @(posedge clk);
      #1;
      applyStimulus(0, 32'h100, 32'h0, 0, rd, st);
      checkOutput("s6Miss", st, 32'd5);
      checkOutput("s6Data", rd, 32'hDEAD_BEEF);
      applyStimulus(0, 32'h18C, 32'h0, 0, rd, st);
      checkOutput("s6PartialMiss", st, 32'd5);
      checkOutput("s6PartialData", rd, 32'hA500_0063);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
